// File: rtl/shift_counter_gen.sv
// Parametrised ring / Johnson shift counter with direction, enable and load.
// Optional lockout recovery: define SHIFT_CNT_SELFCORRECT_EN.
module shift_counter_gen #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] RV =
        (MODE == 0) ? WIDTH'(1) : '0;

    logic             fb_up;
    logic             fb_dn;
    logic [WIDTH-1:0] shifted;
    logic [5:0]       bit_cnt;

    // Next shifted value; Johnson inverts the bit fed back around the ends.
    always_comb begin
        fb_up = (MODE == 0) ? q[WIDTH-1] : ~q[WIDTH-1];
        fb_dn = (MODE == 0) ? q[0] : ~q[0];
        if (dir) begin
            shifted = {fb_dn, q[WIDTH-1:1]};
        end else begin
            shifted = {q[WIDTH-2:0], fb_up};
        end
    end

    // Illegal-state flag: ring needs one hot bit, Johnson at most one edge.
    always_comb begin
        bit_cnt = '0;
        illegal = 1'b0;
        if (MODE == 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                bit_cnt = bit_cnt + 6'(q[i]);
            end
            illegal = (bit_cnt != 6'd1);
        end else begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                bit_cnt = bit_cnt + 6'(q[i] ^ q[i+1]);
            end
            illegal = (bit_cnt > 6'd1);
        end
    end

    // State register and wrap pulse; load beats enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= RV;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
`ifdef SHIFT_CNT_SELFCORRECT_EN
            if (illegal) begin
                q    <= RV;
                wrap <= 1'b0;
            end else begin
                q    <= shifted;
                wrap <= (shifted == RV);
            end
`else
            q    <= shifted;
            wrap <= (shifted == RV);
`endif
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Bench for shift_counter_gen: three instances against a sequence-table model.
// Directed test-plan steps followed by randomized traffic.
module tb_shift_counter_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv_r4 = '0;
    logic [3:0] lv_j4 = '0;
    logic [7:0] lv_j8 = '0;
    logic [3:0] q_r4;
    logic [3:0] q_j4;
    logic [7:0] q_j8;
    logic       w_r4, w_j4, w_j8;
    logic       i_r4, i_j4, i_j8;

    int checks = 0;
    int errors = 0;

    int          wd[3] = '{4, 4, 8};
    int          md[3] = '{0, 1, 1};
    logic [31:0] mq[3];
    logic        mw[3];

    shift_counter_gen #(.WIDTH(4), .MODE(0)) u_r4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(lv_r4), .q(q_r4), .wrap(w_r4), .illegal(i_r4)
    );
    shift_counter_gen #(.WIDTH(4), .MODE(1)) u_j4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(lv_j4), .q(q_j4), .wrap(w_j4), .illegal(i_j4)
    );
    shift_counter_gen #(.WIDTH(8), .MODE(1)) u_j8 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_val(lv_j8), .q(q_j8), .wrap(w_j8), .illegal(i_j8)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mask_of(int w);
        logic [32:0] one = 33'd1;
        return 32'((one << w) - 33'd1);
    endfunction

    function automatic int period(int w, int m);
        return (m == 0) ? w : 2 * w;
    endfunction

    // k-th state of the sequence starting from the reset value.
    function automatic logic [31:0] seq_val(int w, int m, int k);
        logic [31:0] one = 32'd1;
        if (m == 0) return one << k;
        if (k <= w) return (one << k) - 32'd1;
        return mask_of(w) & ~((one << (k - w)) - 32'd1);
    endfunction

    function automatic int seq_idx(int w, int m, logic [31:0] v);
        for (int k = 0; k < period(w, m); k++)
            if (seq_val(w, m, k) == v) return k;
        return -1;
    endfunction

    function automatic logic [31:0] get_q(int i);
        if (i == 0) return 32'(q_r4);
        if (i == 1) return 32'(q_j4);
        return 32'(q_j8);
    endfunction

    function automatic logic get_w(int i);
        if (i == 0) return w_r4;
        if (i == 1) return w_j4;
        return w_j8;
    endfunction

    function automatic logic get_i(int i);
        if (i == 0) return i_r4;
        if (i == 1) return i_j4;
        return i_j8;
    endfunction

    function automatic logic [31:0] get_lv(int i);
        if (i == 0) return 32'(lv_r4);
        if (i == 1) return 32'(lv_j4);
        return 32'(lv_j8);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = seq_val(wd[i], md[i], 0);
            mw[i] = 1'b0;
        end
    endtask

    // Legal states step along the sequence; illegal ones follow the bit rule.
    task automatic model_edge();
        int          w, m, p, idx;
        logic [31:0] q, inv, msk, nq;
        for (int i = 0; i < 3; i++) begin
            w = wd[i];
            m = md[i];
            p = period(w, m);
            q = mq[i];
            msk = mask_of(w);
            if (load) begin
                mq[i] = get_lv(i) & msk;
                mw[i] = 1'b0;
            end else if (en) begin
                idx = seq_idx(w, m, q);
                if (idx >= 0) begin
                    idx = dir ? (idx + p - 1) % p : (idx + 1) % p;
                    mq[i] = seq_val(w, m, idx);
                    mw[i] = (idx == 0);
                end else begin
`ifdef SHIFT_CNT_SELFCORRECT_EN
                    mq[i] = seq_val(w, m, 0);
                    mw[i] = 1'b0;
`else
                    inv = (m == 0) ? q : ~q;
                    if (dir)
                        nq = (q >> 1) | ((inv & 32'd1) << (w - 1));
                    else
                        nq = (q << 1) | ((inv >> (w - 1)) & 32'd1);
                    mq[i] = nq & msk;
                    mw[i] = (mq[i] == seq_val(w, m, 0));
`endif
                end
            end else begin
                mw[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic ill;
        for (int i = 0; i < 3; i++) begin
            ill = (seq_idx(wd[i], md[i], mq[i]) < 0);
            chk($sformatf("%s.q%0d", tag, i), get_q(i), mq[i]);
            chk($sformatf("%s.wrap%0d", tag, i), 32'(get_w(i)), 32'(mw[i]));
            chk($sformatf("%s.ill%0d", tag, i), 32'(get_i(i)), 32'(ill));
        end
    endtask

    task automatic cycle(input logic e, input logic d, input logic l,
                         input string tag);
        en = e;
        dir = d;
        load = l;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        en = 1'b0;
        load = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [3:0] jexp[8] = '{4'h1, 4'h3, 4'h7, 4'hf, 4'he, 4'hc, 4'h8, 4'h0};
    logic [3:0] rexp[4] = '{4'h8, 4'h4, 4'h2, 4'h1};
    logic [3:0] dexp[3] = '{4'h3, 4'h1, 4'h0};
    logic [3:0] sexp[5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

    initial begin
        model_reset();
        @(negedge clk);
        check_all("reset");
        chk("reset_r4", 32'(q_r4), 32'h1);
        chk("reset_j4", 32'(q_j4), 32'h0);
        rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, 1'b0, "john_fwd");
            chk("john_fwd_q", 32'(q_j4), 32'(jexp[k]));
            chk("john_fwd_w", 32'(w_j4), 32'(k == 7));
            chk("john_fwd_i", 32'(i_j4), 32'h0);
        end

        do_reset("rst2");
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b0, "ring_rev");
            chk("ring_rev_q", 32'(q_r4), 32'(rexp[k]));
            chk("ring_rev_w", 32'(w_r4), 32'(k == 3));
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b0, "ring_hold");
            chk("ring_hold_q", 32'(q_r4), 32'h1);
            chk("ring_hold_w", 32'(w_r4), 32'h0);
        end

        do_reset("rst3");
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 1'b0, 1'b0, "john_up");
        chk("john_up_q", 32'(q_j4), 32'h7);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0, "john_dn");
            chk("john_dn_q", 32'(q_j4), 32'(dexp[k]));
            chk("john_dn_w", 32'(w_j4), 32'(k == 2));
        end

        do_reset("rst4");
        lv_r4 = 4'b1010;
        cycle(1'b1, 1'b0, 1'b1, "load_ill");
        chk("load_ill_q", 32'(q_r4), 32'ha);
        chk("load_ill_i", 32'(i_r4), 32'h1);
        chk("load_ill_w", 32'(w_r4), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, "ill_step");
`ifdef SHIFT_CNT_SELFCORRECT_EN
        chk("ill_step_q", 32'(q_r4), 32'h1);
`else
        chk("ill_step_q", 32'(q_r4), 32'h5);
`endif
        chk("ill_step_w", 32'(w_r4), 32'h0);

        lv_r4 = 4'b0000;
        cycle(1'b0, 1'b0, 1'b1, "load_zero");
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, "zero_run");
`ifdef SHIFT_CNT_SELFCORRECT_EN
            chk("zero_run_q", 32'(q_r4), 32'(sexp[k]));
            chk("zero_run_w", 32'(w_r4), 32'(k == 4));
`else
            chk("zero_run_q", 32'(q_r4), 32'h0);
            chk("zero_run_i", 32'(i_r4), 32'h1);
`endif
        end

        lv_r4 = 4'h1;
        cycle(1'b0, 1'b0, 1'b1, "load_rv");
        chk("load_rv_w", 32'(w_r4), 32'h0);

        do_reset("rst6");
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 1'b0, 1'b0, "j8_up");
        chk("j8_up_q", 32'(q_j8), 32'h0f);
        en = 1'b0;
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b0;
        #1;
        chk("async_q", 32'(q_j8), 32'h00);
        chk("async_w", 32'(w_j8), 32'h0);
        model_reset();
        check_all("async");
        en = 1'b1;
        @(negedge clk);
        check_all("rst_hold");
        @(negedge clk);
        check_all("rst_hold2");
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, "resume");
        chk("resume_q", 32'(q_j8), 32'h01);

        for (int n = 0; n < 400; n++) begin
            lv_r4 = 4'($urandom);
            lv_j4 = 4'($urandom);
            lv_j8 = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 15) == 0, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
